// File: rtl/blinky_seq_pkg.sv
// Shared definitions for the blinky LED pattern sequencer: FSM states,
// config register offsets and register bit positions.
package blinky_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DWELL = 2'd2,
    NEXT  = 2'd3
  } seq_state_t;

  // Config register word offsets
  localparam logic [2:0] REG_CTRL      = 3'd0;
  localparam logic [2:0] REG_STATUS    = 3'd1;
  localparam logic [2:0] REG_STEP_BASE = 3'd2;

  // CTRL bit positions
  localparam int CTRL_RUN      = 0;
  localparam int CTRL_LOOP     = 1;
  localparam int CTRL_LAST_LSB = 4;
  localparam int LAST_W        = 2;

  // STATUS bit positions
  localparam int STAT_BUSY    = 0;
  localparam int STAT_IDX_LSB = 2;
  localparam int STAT_IDX_W   = 2;
  localparam int STAT_DONE    = 4;

  // STEP register: dwell field starts here, pattern sits at bit 0
  localparam int DWELL_LSB = 16;

endpackage

// File: rtl/blinky_tick_gen.sv
// Dwell prescaler: counts 0..TICK_DIV-1 and flags the wrap cycle.
// Held at zero while clr is high so every dwell starts on a fresh tick.
module blinky_tick_gen
  import blinky_seq_pkg::*;
#(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Free-running prescaler, cleared by reset or clr, wraps at TICK_DIV-1
  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = (cnt == CNT_MAX) && !clr;

endmodule

// File: rtl/blinky_led_sequencer.sv
// LED pattern sequencer: steps through a small table of pattern/dwell
// entries and pushes each pattern to the LED PIO with a one-cycle
// Avalon-MM write. Configured through a zero-wait Avalon-MM slave.
module blinky_led_sequencer
  import blinky_seq_pkg::*;
#(
  parameter int LED_W    = 2,
  parameter int DEPTH    = 4,
  parameter int TICK_DIV = 50000,
  parameter int DWELL_W  = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  cfg_address,
  input  logic        cfg_chipselect,
  input  logic        cfg_write_n,
  input  logic [31:0] cfg_writedata,
  output logic [31:0] cfg_readdata,
  output logic [1:0]  pio_address,
  output logic        pio_chipselect,
  output logic        pio_write_n,
  output logic [31:0] pio_writedata,
  output logic        busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  seq_state_t         state;
  logic [IDX_W-1:0]   idx;
  logic [DWELL_W-1:0] dwell_cnt;
  logic               ctrl_run;
  logic               ctrl_loop;
  logic [LAST_W-1:0]  ctrl_last;
  logic               done;
  logic [LED_W-1:0]   step_pat   [DEPTH];
  logic [DWELL_W-1:0] step_dwell [DEPTH];

  logic               cfg_wr;
  logic [2:0]         step_off;
  logic               step_hit;
  logic [IDX_W-1:0]   step_sel;
  logic [IDX_W-1:0]   last_eff;
  logic [IDX_W-1:0]   next_step;
  logic               at_last;
  logic               seq_end;
  logic               tick;
  logic               unused_wdata;

  assign cfg_wr   = cfg_chipselect && !cfg_write_n;
  assign step_off = cfg_address - REG_STEP_BASE;
  assign step_hit = (cfg_address >= REG_STEP_BASE) && (32'(step_off) < DEPTH);
  assign step_sel = IDX_W'(step_off);

  // A last index beyond the table clamps to the final entry
  assign last_eff  = (32'(ctrl_last) >= DEPTH) ? IDX_W'(DEPTH - 1) : IDX_W'(ctrl_last);
  assign at_last   = (idx == last_eff);
  assign next_step = at_last ? '0 : idx + IDX_W'(1);
  // Natural end of a non-looping pass: sets done and drops run
  assign seq_end   = ctrl_run && (state == NEXT) && at_last && !ctrl_loop;

  assign pio_address  = 2'd0;
  assign busy         = (state != IDLE);
  assign unused_wdata = ^cfg_writedata;

  blinky_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (state != DWELL),
    .tick    (tick)
  );

  // Config registers; a CPU CTRL write beats the end-of-pass run clear,
  // and a done set beats a simultaneous write-1-to-clear
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ctrl_run  <= 1'b0;
      ctrl_loop <= 1'b0;
      ctrl_last <= '0;
      done      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        step_pat[i]   <= '0;
        step_dwell[i] <= '0;
      end
    end else begin
      if (cfg_wr && (cfg_address == REG_CTRL)) begin
        ctrl_run  <= cfg_writedata[CTRL_RUN];
        ctrl_loop <= cfg_writedata[CTRL_LOOP];
        ctrl_last <= cfg_writedata[CTRL_LAST_LSB +: LAST_W];
      end else if (seq_end) begin
        ctrl_run <= 1'b0;
      end
      if (seq_end) begin
        done <= 1'b1;
      end else if (cfg_wr && (cfg_address == REG_STATUS) && cfg_writedata[STAT_DONE]) begin
        done <= 1'b0;
      end
      if (cfg_wr && step_hit) begin
        step_pat[step_sel]   <= cfg_writedata[LED_W-1:0];
        step_dwell[step_sel] <= cfg_writedata[DWELL_LSB +: DWELL_W];
      end
    end
  end

  // Sequencer FSM with registered PIO strobe; the strobe is raised on
  // entry to WRITE so it is visible for exactly the WRITE cycle
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      idx            <= '0;
      dwell_cnt      <= '0;
      pio_chipselect <= 1'b0;
      pio_write_n    <= 1'b1;
      pio_writedata  <= '0;
    end else begin
      pio_chipselect <= 1'b0;
      pio_write_n    <= 1'b1;
      if (!ctrl_run) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            idx            <= '0;
            state          <= WRITE;
            pio_chipselect <= 1'b1;
            pio_write_n    <= 1'b0;
            pio_writedata  <= 32'(step_pat[0]);
          end
          WRITE: begin
            dwell_cnt <= (step_dwell[idx] == '0) ? DWELL_W'(1) : step_dwell[idx];
            state     <= DWELL;
          end
          DWELL: begin
            if (tick) begin
              dwell_cnt <= dwell_cnt - DWELL_W'(1);
              if (dwell_cnt == DWELL_W'(1)) begin
                state <= NEXT;
              end
            end
          end
          NEXT: begin
            if (at_last && !ctrl_loop) begin
              state <= IDLE;
            end else begin
              idx            <= next_step;
              state          <= WRITE;
              pio_chipselect <= 1'b1;
              pio_write_n    <= 1'b0;
              pio_writedata  <= 32'(step_pat[next_step]);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Config read mux, combinational from address
  always_comb begin
    cfg_readdata = '0;
    if (cfg_address == REG_CTRL) begin
      cfg_readdata[CTRL_RUN]                  = ctrl_run;
      cfg_readdata[CTRL_LOOP]                 = ctrl_loop;
      cfg_readdata[CTRL_LAST_LSB +: LAST_W]   = ctrl_last;
    end else if (cfg_address == REG_STATUS) begin
      cfg_readdata[STAT_BUSY]                 = busy;
      cfg_readdata[STAT_IDX_LSB +: STAT_IDX_W] = STAT_IDX_W'(idx);
      cfg_readdata[STAT_DONE]                 = done;
    end else if (step_hit) begin
      cfg_readdata[LED_W-1:0]                 = step_pat[step_sel];
      cfg_readdata[DWELL_LSB +: DWELL_W]      = step_dwell[step_sel];
    end
  end

endmodule

// File: tb/tb_blinky_led_sequencer.sv
// Directed bench for blinky_led_sequencer with TICK_DIV=4.
// Inputs change on the falling edge; outputs are checked there too.
module tb_blinky_led_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  cfg_address;
  logic        cfg_chipselect;
  logic        cfg_write_n;
  logic [31:0] cfg_writedata;
  logic [31:0] cfg_readdata;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int strobes = 0;
  int snap;

  blinky_led_sequencer #(
    .LED_W    (2),
    .DEPTH    (4),
    .TICK_DIV (4),
    .DWELL_W  (16)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cfg_address    (cfg_address),
    .cfg_chipselect (cfg_chipselect),
    .cfg_write_n    (cfg_write_n),
    .cfg_writedata  (cfg_writedata),
    .cfg_readdata   (cfg_readdata),
    .pio_address    (pio_address),
    .pio_chipselect (pio_chipselect),
    .pio_write_n    (pio_write_n),
    .pio_writedata  (pio_writedata),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Count PIO write strobes, one per full-cycle pulse
  always @(negedge clk) begin
    if (pio_chipselect && !pio_write_n) strobes++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; the write lands on the next rising edge
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    cfg_address    = a;
    cfg_writedata  = d;
    cfg_chipselect = 1'b1;
    cfg_write_n    = 1'b0;
    @(negedge clk);
    cfg_chipselect = 1'b0;
    cfg_write_n    = 1'b1;
    cfg_writedata  = '0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
    cfg_address = a;
    #1;
    chk(tag, cfg_readdata, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pio_strobe(input string tag, input logic [31:0] pat);
    chk({tag, "_cs"}, {31'd0, pio_chipselect}, 32'd1);
    chk({tag, "_wn"}, {31'd0, pio_write_n}, 32'd0);
    chk({tag, "_wd"}, pio_writedata, pat);
  endtask

  initial begin
    reset_n        = 1'b0;
    cfg_address    = '0;
    cfg_chipselect = 1'b0;
    cfg_write_n    = 1'b1;
    cfg_writedata  = '0;

    // ---- reset ----
    cyc(3);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cs", {31'd0, pio_chipselect}, 32'd0);
    chk("rst_wn", {31'd0, pio_write_n}, 32'd1);
    chk("rst_wd", pio_writedata, 32'd0);
    chk("rst_addr", {30'd0, pio_address}, 32'd0);
    reset_n = 1'b1;
    for (int a = 0; a < 8; a++) rd(3'(a), 32'd0, "rst_read");
    @(negedge clk);

    // ---- single pass: STEP0 {1,2}, STEP1 {2,1}, run, last=1 ----
    wr(3'd2, {16'd2, 16'd1});
    wr(3'd3, {16'd1, 16'd2});
    rd(3'd2, 32'h0002_0001, "step0_rb");
    wr(3'd6, 32'hFFFF_FFFF);
    rd(3'd6, 32'd0, "unmapped_rb");
    snap = strobes;
    wr(3'd0, 32'h11);
    chk("sp_n_cs", {31'd0, pio_chipselect}, 32'd0);
    cyc(1);
    pio_strobe("sp_w1", 32'd1);
    chk("sp_busy", {31'd0, busy}, 32'd1);
    cyc(9);
    chk("sp_gap_cs", {31'd0, pio_chipselect}, 32'd0);
    cyc(1);
    pio_strobe("sp_w2", 32'd2);
    rd(3'd1, 32'h05, "sp_stat_idx1");
    cyc(6);
    chk("sp_end_busy", {31'd0, busy}, 32'd0);
    rd(3'd1, 32'h14, "sp_end_status");
    rd(3'd0, 32'h10, "sp_end_ctrl");
    chk("sp_strobes", 32'(strobes - snap), 32'd2);

    // ---- W1C done ----
    wr(3'd1, 32'h10);
    rd(3'd1, 32'h04, "w1c_status");

    // ---- loop wrap then abort during STEP0 dwell ----
    wr(3'd0, 32'h13);
    cyc(1);
    pio_strobe("lp_w1", 32'd1);
    cyc(10);
    pio_strobe("lp_w2", 32'd2);
    cyc(6);
    pio_strobe("lp_w3", 32'd1);
    rd(3'd1, 32'h01, "lp_stat_wrap");
    cyc(2);
    snap = strobes;
    wr(3'd0, 32'h12);
    cyc(1);
    chk("ab_busy", {31'd0, busy}, 32'd0);
    rd(3'd1, 32'h00, "ab_status");
    cyc(20);
    chk("ab_strobes", 32'(strobes - snap), 32'd0);
    chk("ab_hold_wd", pio_writedata, 32'd1);

    // ---- dwell zero and live edit of STEP1 ----
    wr(3'd2, {16'd0, 16'd1});
    wr(3'd0, 32'h11);
    cyc(1);
    pio_strobe("dz_w1", 32'd1);
    cyc(1);
    wr(3'd3, {16'd1, 16'd3});
    cyc(3);
    chk("dz_gap_cs", {31'd0, pio_chipselect}, 32'd0);
    cyc(1);
    pio_strobe("dz_w2", 32'd3);
    cyc(6);
    rd(3'd1, 32'h14, "dz_end_status");

    // ---- contention: CTRL run=1 on the end-of-pass edge ----
    wr(3'd1, 32'h10);
    wr(3'd0, 32'h11);
    cyc(12);
    wr(3'd0, 32'h11);
    rd(3'd0, 32'h11, "ct_run_kept");
    rd(3'd1, 32'h14, "ct_status");
    cyc(1);
    pio_strobe("ct_restart", 32'd1);
    rd(3'd1, 32'h11, "ct_restart_stat");

    // ---- contention: W1C done on the done-set edge ----
    cyc(11);
    wr(3'd1, 32'h10);
    rd(3'd1, 32'h14, "w1c_set_wins");
    rd(3'd0, 32'h10, "w1c_ctrl");

    // ---- reset during a WRITE cycle ----
    wr(3'd0, 32'h11);
    cyc(1);
    pio_strobe("mr_w1", 32'd1);
    reset_n = 1'b0;
    cyc(1);
    chk("mr_cs", {31'd0, pio_chipselect}, 32'd0);
    chk("mr_wn", {31'd0, pio_write_n}, 32'd1);
    chk("mr_wd", pio_writedata, 32'd0);
    chk("mr_busy", {31'd0, busy}, 32'd0);
    rd(3'd0, 32'd0, "mr_ctrl");
    rd(3'd3, 32'd0, "mr_step1");
    reset_n = 1'b1;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
